// File: rtl/addlist_pkg.sv
// Shared types and constants for the addlist feeder and the addlist consumer.
// Pure declarations, no logic; latency not applicable.
// No flow control here; the feeder and the consumer handle backpressure themselves.
package addlist_pkg;

  localparam int BUF_SIZE = 4;
  localparam int WORD_W   = 32;

  typedef logic [WORD_W-1:0] float_t;
  typedef float_t batch_t [BUF_SIZE];

  // IEEE-754 +0.0, used to pad short final batches so addlist sums are unaffected
  localparam float_t FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/addlist_feeder_if.sv
// Stream-in / batch-out bundle between a float32 source, the feeder and addlist.
// Wires only, zero latency.
// Input side is valid/ready; batch side is data_provided/data_requested.
interface addlist_feeder_if #(
  parameter int BUF_SIZE = addlist_pkg::BUF_SIZE,
  parameter int WORD_W   = addlist_pkg::WORD_W
);

  logic [WORD_W-1:0]                in_data;
  logic                             in_valid;
  logic                             in_last;
  logic                             in_ready;
  logic [BUF_SIZE-1:0][WORD_W-1:0]  buffer;
  logic                             data_provided;
  logic                             data_requested;
  logic                             batch_last;

  // Source/consumer side: drives the stream and the batch request
  modport master (
    output in_data, in_valid, in_last, data_requested,
    input  in_ready, buffer, data_provided, batch_last
  );

  // Feeder side
  modport slave (
    input  in_data, in_valid, in_last, data_requested,
    output in_ready, buffer, data_provided, batch_last
  );

endinterface

// File: rtl/addlist_bank.sv
// One ping-pong bank: word write port, commit with zero padding, full/last flags.
// A written word is visible on o_data one cycle after the write edge.
// Writer must not write while o_full=1; i_clear empties the bank for reuse.
module addlist_bank #(
  parameter int BUF_SIZE = addlist_pkg::BUF_SIZE,
  parameter int WORD_W   = addlist_pkg::WORD_W,
  parameter int PW       = $clog2(BUF_SIZE)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_wr_en,
  input  logic [PW-1:0]                   i_wr_idx,
  input  logic [WORD_W-1:0]               i_wr_data,
  input  logic                            i_commit,
  input  logic                            i_last,
  input  logic                            i_clear,
  output logic                            o_full,
  output logic                            o_last,
  output logic [BUF_SIZE-1:0][WORD_W-1:0] o_data
);
  import addlist_pkg::*;

  logic [BUF_SIZE-1:0][WORD_W-1:0] r_mem;
  logic                            r_full;
  logic                            r_last;

  // Word storage plus flags; a short final batch is zero-padded on the committing edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem  <= '0;
      r_full <= 1'b0;
      r_last <= 1'b0;
    end else begin
      if (i_wr_en) begin
        r_mem[i_wr_idx] <= i_wr_data;
        if (i_commit) begin
          r_full <= 1'b1;
          r_last <= i_last;
          if (i_last) begin
            for (int i = 0; i < BUF_SIZE; i++) begin
              if (i > int'(i_wr_idx)) r_mem[i] <= WORD_W'(FP_ZERO);
            end
          end
        end
      end
      // Writes and clears never target the same bank in one cycle: a bank is
      // written only while empty and cleared only while full.
      if (i_clear) begin
        r_full <= 1'b0;
        r_last <= 1'b0;
      end
    end
  end

  assign o_full = r_full;
  assign o_last = r_last;
  assign o_data = r_mem;

endmodule

// File: rtl/addlist_feeder.sv
// Packs a float32 word stream into BUF_SIZE-word batches for addlist via two ping-pong banks.
// data_provided rises the cycle after the committing accept when that bank is the read bank.
// in_ready drops while both banks are full and rises the cycle after the next handoff.
module addlist_feeder #(
  parameter int BUF_SIZE = addlist_pkg::BUF_SIZE,
  parameter int WORD_W   = addlist_pkg::WORD_W
) (
  input  logic            clk,
  input  logic            rst,
  addlist_feeder_if.slave io_feed
);
  import addlist_pkg::*;

  localparam int            PW       = $clog2(BUF_SIZE);
  localparam logic [PW-1:0] LAST_IDX = PW'(BUF_SIZE - 1);

  logic [PW-1:0] r_wr_ptr;
  logic          r_wr_bank;
  logic          r_rd_bank;

  logic [1:0]                      w_full;
  logic [1:0]                      w_last;
  logic [1:0]                      w_wr_en;
  logic [1:0]                      w_clear;
  logic [BUF_SIZE-1:0][WORD_W-1:0] w_data [2];

  logic w_wr_full;
  logic w_rd_full;
  logic w_accept;
  logic w_commit;
  logic w_handoff;

  assign w_wr_full = w_full[r_wr_bank];
  assign w_rd_full = w_full[r_rd_bank];

  assign io_feed.in_ready = ~rst & ~w_wr_full;

  assign w_accept  = io_feed.in_valid & io_feed.in_ready;
  // A batch closes on its last slot or early on the list's final word
  assign w_commit  = w_accept & ((r_wr_ptr == LAST_IDX) | io_feed.in_last);
  assign w_handoff = w_rd_full & io_feed.data_requested;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign w_wr_en[b] = w_accept  & (r_wr_bank == 1'(b));
    assign w_clear[b] = w_handoff & (r_rd_bank == 1'(b));

    addlist_bank #(
      .BUF_SIZE (BUF_SIZE),
      .WORD_W   (WORD_W),
      .PW       (PW)
    ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_wr_en[b]),
      .i_wr_idx  (r_wr_ptr),
      .i_wr_data (io_feed.in_data),
      .i_commit  (w_commit),
      .i_last    (io_feed.in_last),
      .i_clear   (w_clear[b]),
      .o_full    (w_full[b]),
      .o_last    (w_last[b]),
      .o_data    (w_data[b])
    );
  end

  // Write pointer and bank selects; commit and handoff act on different banks so both may fire
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
    end else begin
      if (w_commit) begin
        r_wr_ptr  <= '0;
        r_wr_bank <= ~r_wr_bank;
      end else if (w_accept) begin
        r_wr_ptr  <= r_wr_ptr + 1'b1;
      end
      if (w_handoff) begin
        r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  assign io_feed.data_provided = w_rd_full;
  assign io_feed.batch_last    = w_rd_full & w_last[r_rd_bank];
  assign io_feed.buffer        = w_data[r_rd_bank];

endmodule

// File: doc/addlist_feeder.md
ADDLIST_FEEDER -- requirements
Module: addlist_feeder

Interface
REQ-001 Parameter BUF_SIZE, default 4, words per batch delivered to addlist (power of two, >=2).
REQ-002 Parameter WORD_W, default 32, IEEE-754 single-precision word width.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_data  input  WORD_W  float32 stream word.
REQ-006 in_valid  input  1  in_data valid this cycle.
REQ-007 in_last  input  1  qualifies in_data as final word of the list.
REQ-008 in_ready  output  1  feeder accepts a word this cycle.
REQ-009 buffer  output  BUF_SIZE x WORD_W  batch presented to addlist.
REQ-010 data_provided  output  1  buffer holds a complete, stable batch.
REQ-011 data_requested  input  1  addlist is ready to take a batch.
REQ-012 batch_last  output  1  presented batch is the final batch of the list; valid while data_provided=1.

Function
REQ-013 Storage SHALL be two banks of BUF_SIZE words (ping-pong): one write bank, one read bank, each with a full flag and a last flag.
REQ-014 Input accept SHALL occur on posedge with in_valid=1 and in_ready=1; word written to write bank at wr_ptr, wr_ptr incremented.
REQ-015 in_ready SHALL equal (not rst) and (write bank not full), combinationally.
REQ-016 Write bank SHALL commit (full flag set, wr_ptr cleared to 0, write bank toggles) on the accept of word index BUF_SIZE-1 or of any word with in_last=1.
REQ-017 On commit by in_last with fewer than BUF_SIZE words, all slots above the written index SHALL be set to +0.0 (32'h00000000) in the same edge; bank last flag set.
REQ-018 in_last on word index BUF_SIZE-1 SHALL commit without padding and set the last flag.
REQ-019 data_provided SHALL equal the read bank full flag; buffer SHALL show read bank contents, stable while data_provided=1.
REQ-020 Latency: data_provided SHALL rise in the cycle after the posedge accepting the committing word, when that bank is the read bank.
REQ-021 Handoff SHALL occur on posedge with data_provided=1 and data_requested=1; read bank full flag cleared, read bank toggles.
REQ-022 If the other bank is full at handoff, data_provided SHALL remain 1 and buffer SHALL switch to it in the next cycle (back-to-back batches).
REQ-023 Commit and handoff on the same edge SHALL both take effect; no word loss, no duplicate batch.
REQ-024 Both banks full: in_ready=0 until the next handoff; in_ready rises the cycle after it.
REQ-025 data_requested=1 with data_provided=0 SHALL have no effect; in_valid=0 SHALL leave wr_ptr unchanged.
REQ-026 Batches SHALL be delivered in input order; word i of a batch at buffer[i].

Reset
REQ-027 On rst: both full and last flags 0, wr_ptr 0, both bank indices 0, all bank words 32'h0.
REQ-028 Reset values: data_provided=0, batch_last=0, buffer all 0, in_ready=0 while rst=1, 1 in the first cycle after release.
REQ-029 Reset mid-batch SHALL discard partial and pending batches; no batch emitted after release until newly committed.

Structure
REQ-030 Shared package addlist_pkg SHALL hold BUF_SIZE, WORD_W, float_t (logic [WORD_W-1:0]), batch_t (float_t array [BUF_SIZE]) and FP_ZERO constant; addlist uses the same package.
REQ-031 One sub-module addlist_bank SHALL implement a single bank (write port, commit-with-pad, full/last flags); instantiated twice.
REQ-032 Estimated size 150-250 lines RTL; no arithmetic on float contents.

Verification
REQ-033 Eight words 1.0 (32'h3F800000) streamed with in_valid=1, data_requested=1 -> two batches of four 1.0, first data_provided high cycle after 4th accept, batch_last=1 on second only.
REQ-034 Six words, in_last on 6th, data_requested=1 -> batch 2 = {w4,w5,32'h0,32'h0}, batch_last=1.
REQ-035 data_requested=0, twelve words offered -> in_ready drops after 8 accepts, buffer holds words 0-3 stable; raise data_requested -> words 0-3, 4-7, 8-11 delivered back-to-back, data_provided continuously 1.
REQ-036 rst pulsed after 2 words of a batch -> data_provided=0, buffer zeros; next four words form first batch exactly.
REQ-037 Scoreboard run with addlist: 16-word list (31165.95 expected sum 32'h46F37BE8) -> addlist result equals expected.
